// File: rtl/sram_cpu_bridge.sv
// Single-word CPU bus master for the 48-bit SRAM controller, with per-access timeout.
// Define SRAM_BRIDGE_POSTED_WRITE_EN to ack writes early and run them in the background.
module sram_cpu_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stb,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_sel,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        mem_stb,
  output logic [31:0] mem_addr,
  output logic [5:0]  mem_we,
  output logic [47:0] mem_din,
  input  logic [47:0] mem_dout,
  input  logic        mem_nak,
  output logic        write_err
);

`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED_EN = 1'b1;
`else
  localparam bit POSTED_EN = 1'b0;
`endif

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, ERR} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] cpu_dout_reg, cpu_dout_next;
  logic        cpu_ack_reg, cpu_ack_next;
  logic        cpu_err_reg, cpu_err_next;
  logic        mem_stb_reg, mem_stb_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [5:0]  mem_we_reg, mem_we_next;
  logic [47:0] mem_din_reg, mem_din_next;
  logic        wr_reg, wr_next;
  logic        posted_reg, posted_next;
  logic        write_err_reg, write_err_next;
  logic        unused_bits;

  assign unused_bits = ^{mem_dout[47:32], cpu_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cpu_dout_reg  <= '0;
      cpu_ack_reg   <= 1'b0;
      cpu_err_reg   <= 1'b0;
      mem_stb_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_we_reg    <= '0;
      mem_din_reg   <= '0;
      wr_reg        <= 1'b0;
      posted_reg    <= 1'b0;
      write_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cpu_dout_reg  <= cpu_dout_next;
      cpu_ack_reg   <= cpu_ack_next;
      cpu_err_reg   <= cpu_err_next;
      mem_stb_reg   <= mem_stb_next;
      mem_addr_reg  <= mem_addr_next;
      mem_we_reg    <= mem_we_next;
      mem_din_reg   <= mem_din_next;
      wr_reg        <= wr_next;
      posted_reg    <= posted_next;
      write_err_reg <= write_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cpu_dout_next  = cpu_dout_reg;
    cpu_ack_next   = 1'b0;
    cpu_err_next   = 1'b0;
    mem_stb_next   = mem_stb_reg;
    mem_addr_next  = mem_addr_reg;
    mem_we_next    = mem_we_reg;
    mem_din_next   = mem_din_reg;
    wr_next        = wr_reg;
    posted_next    = posted_reg;
    write_err_next = write_err_reg;

    case (state_reg)
      IDLE: begin
        // A strobe seen during our own ack cycle belongs to the request just finished.
        if (cpu_stb && !cpu_ack_reg) begin
          mem_addr_next = {cpu_addr[31:2], 2'b00};
          mem_we_next   = cpu_we ? {2'b00, cpu_sel} : 6'd0;
          mem_din_next  = {16'h0000, cpu_din};
          wr_next       = cpu_we;
          mem_stb_next  = 1'b1;
          cnt_next      = '0;
          posted_next   = POSTED_EN && cpu_we;
          cpu_ack_next  = POSTED_EN && cpu_we;
          state_next    = ISSUE;
        end
      end
      ISSUE, BUSY: begin
        cnt_next = cnt_reg + 8'd1;
        if (state_reg == BUSY && !mem_nak) begin
          if (!wr_reg) cpu_dout_next = mem_dout[31:0];
          cpu_ack_next = !posted_reg;
          posted_next  = 1'b0;
          state_next   = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          // Background writes report through the sticky flag, never through the bus.
          mem_stb_next = 1'b0;
          if (posted_reg) begin
            write_err_next = 1'b1;
            posted_next    = 1'b0;
            state_next     = IDLE;
          end else begin
            state_next = ERR;
          end
        end else if (state_reg == ISSUE && mem_nak) begin
          mem_stb_next = 1'b0;
          state_next   = BUSY;
        end
      end
      ERR: begin
        cpu_ack_next = 1'b1;
        cpu_err_next = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_dout  = cpu_dout_reg;
  assign cpu_ack   = cpu_ack_reg;
  assign cpu_err   = cpu_err_reg;
  assign mem_stb   = mem_stb_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_we    = mem_we_reg;
  assign mem_din   = mem_din_reg;
  assign write_err = write_err_reg;

endmodule

// File: tb/tb_sram_cpu_bridge.sv
// Self-checking bench for sram_cpu_bridge: controller model, ack scoreboard, directed sequences.
// Posted-write checks are compiled in when SRAM_BRIDGE_POSTED_WRITE_EN is defined.
module tb_sram_cpu_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_stb = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_sel = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_din = '0;
  logic [31:0] cpu_dout;
  logic        cpu_ack;
  logic        cpu_err;
  logic        mem_stb;
  logic [31:0] mem_addr;
  logic [5:0]  mem_we;
  logic [47:0] mem_din;
  logic [47:0] mem_dout = '0;
  logic        mem_nak;
  logic        write_err;

  sram_cpu_bridge #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .mem_stb(mem_stb), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_nak(mem_nak), .write_err(write_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM controller model: a strobe seen while idle raises nak for two cycles.
  logic [47:0] mem [0:63];
  int          nak_cnt = 0;
  bit          hang = 1'b0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 48'h0;
    mem[4] <= 48'hABCD_1234_5678;
    mem[0] <= 48'h7777_CAFE_0000;
    mem[1] <= 48'h8888_0000_BEEF;
  end

  always @(posedge clk) begin
    if (nak_cnt != 0) begin
      nak_cnt <= nak_cnt - 1;
    end else if (mem_stb && !hang) begin
      nak_cnt <= 2;
      if (mem_we != 6'd0) begin
        for (int i = 0; i < 4; i++)
          if (mem_we[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_din[8*i +: 8];
      end else begin
        mem_dout <= mem[mem_addr[7:2]];
      end
    end
  end

  assign mem_nak = (nak_cnt != 0);

  // Scoreboard of expected ack results.
  typedef struct packed {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [31:0] dout_model = '0;
  int          issues = 0;
  logic        stb_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_stb && !stb_prev) issues++;
    stb_prev = mem_stb;
    if (!rst && cpu_ack) begin
      check("ack_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check("ack_dout", 64'(cpu_dout), 64'(sb_e.dout));
        check("ack_err", 64'(cpu_err), 64'(sb_e.err));
        $display("ack: dout=%08h err=%0b (expected %08h/%0b) t=%0t",
                 cpu_dout, cpu_err, sb_e.dout, sb_e.err, $time);
      end
    end
  end

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] din, input logic [31:0] rd_data, input bit exp_err,
                        input int exp_lat, input int exp_first, input int exp_last);
    int n;
    int first;
    int last;
    if (!we && !exp_err) dout_model = rd_data;
    sb_q.push_back('{dout: dout_model, err: exp_err});
    @(negedge clk);
    cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_din = din; cpu_stb = 1'b1;
    n = 0; first = -1; last = -1;
    while (1) begin
      @(negedge clk);
      n++;
      if (mem_stb) begin
        if (first < 0) begin
          first = n;
          check("mem_addr", 64'(mem_addr), 64'({addr[31:2], 2'b00}));
          check("mem_we", 64'(mem_we), 64'(we ? {2'b00, sel} : 6'h0));
          if (we) check("mem_din", 64'(mem_din), 64'({16'h0000, din}));
        end
        last = n;
      end
      if (cpu_ack || n >= 200) break;
    end
    cpu_stb = 1'b0;
    check("ack_latency", 64'(n), 64'(exp_lat));
    check("stb_first", 64'(first), 64'(exp_first));
    check("stb_last", 64'(last), 64'(exp_last));
    @(negedge clk);
    check("ack_pulse", 64'(cpu_ack), 64'd0);
    check("err_pulse", 64'(cpu_err), 64'd0);
    $display("req: we=%0b addr=%08h latency=%0d stb=%0d..%0d", we, addr, n, first, last);
  endtask

`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
  localparam int WR_LAT = 1;
  localparam int WR_LAST = 1;
`else
  localparam int WR_LAT = 5;
  localparam int WR_LAST = 2;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    int m;
    int iss0;

    #12;
    check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst_mem_stb", 64'(mem_stb), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_cpu_dout", 64'(cpu_dout), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Read, write with partial lanes, read back through an unaligned address.
    do_req(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 5, 1, 2);
    do_req(1'b1, 32'h0000_0024, 4'b0101, 32'hDEAD_BEEF, 32'h0, 1'b0, WR_LAT, 1, WR_LAST);
    repeat (6) @(negedge clk);
    do_req(1'b0, 32'h0000_0026, 4'h0, 32'h0, 32'h00AD_00EF, 1'b0, 5, 1, 2);

    // Controller never answers: abort with error, read data kept.
    hang = 1'b1;
    do_req(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h0, 1'b1, 18, 1, 16);
    hang = 1'b0;
    check("dout_after_timeout", 64'(cpu_dout), 64'h00AD_00EF);

    // Back-to-back reads with the strobe held across the first ack.
    @(negedge clk);
    iss0 = issues;
    dout_model = 32'hCAFE_0000;
    sb_q.push_back('{dout: dout_model, err: 1'b0});
    cpu_we = 1'b0; cpu_addr = 32'h0; cpu_sel = 4'h0; cpu_din = 32'h0; cpu_stb = 1'b1;
    n1 = 0;
    do begin @(negedge clk); n1++; end while (!cpu_ack && n1 < 200);
    cpu_addr = 32'h4;
    dout_model = 32'h0000_BEEF;
    sb_q.push_back('{dout: dout_model, err: 1'b0});
    m = 0;
    do begin @(negedge clk); m++; end while (!cpu_ack && m < 200);
    cpu_stb = 1'b0;
    check("b2b_first_latency", 64'(n1), 64'd5);
    check("b2b_gap", 64'(m), 64'd6);
    @(negedge clk);
    check("b2b_issue_count", 64'(issues - iss0), 64'd2);

    // Reset in the middle of a read: everything clears at once, no ack.
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_stb = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_mem_addr", 64'(mem_addr), 64'h10);
    rst = 1'b1;
    #1;
    check("arst_cpu_dout", 64'(cpu_dout), 64'd0);
    check("arst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("arst_cpu_err", 64'(cpu_err), 64'd0);
    check("arst_mem_stb", 64'(mem_stb), 64'd0);
    check("arst_mem_addr", 64'(mem_addr), 64'd0);
    check("arst_mem_we", 64'(mem_we), 64'd0);
    check("arst_mem_din", 64'(mem_din), 64'd0);
    check("arst_write_err", 64'(write_err), 64'd0);
    cpu_stb = 1'b0;
    dout_model = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 5, 1, 2);

`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
    // Early write ack, then a read that stalls until the background write is done.
    do_req(1'b1, 32'h0000_0030, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, 1, 1, 1);
    do_req(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 7, 3, 4);
    do_req(1'b0, 32'h0000_0030, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, 5, 1, 2);
    check("posted_write_err_clear", 64'(write_err), 64'd0);
    hang = 1'b1;
    do_req(1'b1, 32'h0000_0034, 4'hF, 32'h1111_2222, 32'h0, 1'b0, 1, 1, 1);
    repeat (20) @(negedge clk);
    hang = 1'b0;
    check("posted_write_err_set", 64'(write_err), 64'd1);
    do_req(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 5, 1, 2);
    check("posted_write_err_sticky", 64'(write_err), 64'd1);
`else
    check("write_err_tied", 64'(write_err), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
